lstm_init_receiver: RTL and testbench
=====================================

Name: lstm_init_receiver

Overview:
- Receive side of the LSTM parameter-initialisation byte stream (iInit_valid / iInit_type / iInit_data).
- Packs bytes into 32-bit words and emits one registered write per word, with region ID and word address, to the weight/bias banks inside LSTM.
- Tracks per-region completion and protocol errors, so the top can confirm all parameter regions are loaded before issuing iNext_valid.

Parameters:
- WORD_BYTES, 4, bytes packed per output word.
- ADDR_W, 13, word-address width; covers the largest region (32768/4 = 8192 words).
- SYS_W_BYTES, 512, syscall weight region size in bytes.
- SYS_B_BYTES, 32, syscall bias region size in bytes.
- BR_W_BYTES, 32768, branch weight region size in bytes.
- BR_B_BYTES, 256, branch bias region size in bytes.
- CONV_W_BYTES, 1024, converter weight region size in bytes.
- CONV_B_BYTES, 128, converter bias region size in bytes.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- iInit_valid  in  1  byte valid; one byte accepted per cycle while high.
- iInit_type  in  3  region: 0 sys_w, 1 sys_b, 2 br_w, 3 br_b, 4 conv_w, 5 conv_b, 7 idle; 6 is illegal.
- iInit_data  in  8  byte payload.
- oWr_en  out  1  one-cycle write strobe.
- oWr_region  out  3  region of the current write.
- oWr_addr  out  ADDR_W  word address within the region.
- oWr_data  out  32  packed word; first byte received lands in [31:24].
- oLoaded  out  6  sticky per-region complete flags, bit index = type.
- oAll_loaded  out  1  &oLoaded.
- oErr_overflow  out  1  one-cycle pulse: byte beyond the region size was dropped.
- oErr_partial  out  1  one-cycle pulse: partial word discarded.
- oErr_type  out  1  one-cycle pulse: byte with type 6 or 7 while valid was dropped.

Behaviour:
- Reset (async, any time, including mid-burst):
  - All outputs 0.
  - Byte counter, packing register and state cleared.
  - oLoaded cleared; every region must be reloaded.
- FSM states: IDLE, RECV, FULL.
- IDLE:
  - valid=1 with legal type: latch the type as the current region, byte count = 0, accept the byte, go to RECV.
  - valid=1 with type 6 or 7: pulse oErr_type, drop the byte, stay in IDLE.
- RECV, each accepted byte:
  - shift into the packing register (MSB first), increment the byte count.
  - When count mod WORD_BYTES reaches 0: on the next cycle oWr_en=1, oWr_addr = count/WORD_BYTES − 1, oWr_region = current type, oWr_data = packed word.
  - Write latency: 1 cycle after the 4th byte is sampled.
  - When count reaches the region size: after the last write, set oLoaded[type] in the same cycle as that write, then go to FULL.
- FULL:
  - Any byte with valid=1 and the same type: dropped, oErr_overflow pulses.
  - valid=0: go to IDLE.
- Burst end in RECV (valid=0):
  - Go to IDLE.
  - If count mod WORD_BYTES ≠ 0: discard the partial word, pulse oErr_partial.
  - Region not complete: oLoaded[type] is unchanged; the next burst of that type restarts at address 0.
- Type change while valid stays 1 (RECV or FULL):
  - Treated as end of the old burst (partial-word rule applies), then start of a new burst with the new type in the same cycle.
  - The new byte is accepted at count 0.
  - An illegal new type goes to IDLE with oErr_type.
- Reloading a region already loaded:
  - oLoaded[type] clears on the first byte of the new burst.
  - It sets again on completion.
- Error pulses may coincide with each other and with oWr_en; each is independent.
- Counter width is 16 bits, sized for BR_W_BYTES. The address is truncated to ADDR_W.

Decomposition:
- Shared package lstm_init_pkg holds:
  - type codes (SYSCALL_W … CONVERT_B, IDLE_T = 7);
  - region byte-size constants;
  - WORD_BYTES;
  - function region_size(type).
- One natural sub-module: lstm_byte_packer (shift register, byte counter, word-ready strobe). The FSM and status logic stay in the top.

Test Plan:
- sys_b, 32 bytes 0x00..0x1F, valid continuous → 8 writes at addr 0..7, region 1:
  - first data 0x00010203, last 0x1C1D1E1F;
  - oLoaded = 6'b000010 in the cycle of the addr-7 write.
- sys_b, 33 bytes → 8 writes as above, plus one oErr_overflow pulse on the 33rd byte; no 9th write.
- sys_w, 6 bytes 0xA0..0xA5, then type switches to br_b with 4 bytes 0x10..0x13, valid held high:
  - one sys_w write, addr 0 = 0xA0A1A2A3;
  - oErr_partial pulse at the switch;
  - br_b write, addr 0 = 0x10111213;
  - oLoaded unchanged.
- Full load of all six regions in the order sys_w, sys_b, br_w, br_b, conv_w, conv_b, with 100 ns gaps:
  - br_w final write at addr 8191;
  - oAll_loaded = 1 after the conv_b final write.
- reset asserted mid br_w at byte 1000 → all outputs 0 asynchronously; after release, a br_w burst restarts at addr 0 and oLoaded = 0.
- valid=1, type=6, 3 bytes → 3 oErr_type pulses, no writes, state stays IDLE.

Source files
------------

// File: rtl/lstm_init_pkg.sv
// Shared type codes, region sizes and helpers for the LSTM parameter-initialisation receiver.
package lstm_init_pkg;

  localparam int unsigned WORD_BYTES   = 4;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned SYS_W_BYTES  = 512;
  localparam int unsigned SYS_B_BYTES  = 32;
  localparam int unsigned BR_W_BYTES   = 32768;
  localparam int unsigned BR_B_BYTES   = 256;
  localparam int unsigned CONV_W_BYTES = 1024;
  localparam int unsigned CONV_B_BYTES = 128;

  typedef enum logic [2:0] {
    SYSCALL_W = 3'd0,
    SYSCALL_B = 3'd1,
    BRANCH_W  = 3'd2,
    BRANCH_B  = 3'd3,
    CONVERT_W = 3'd4,
    CONVERT_B = 3'd5,
    ILLEGAL_T = 3'd6,
    IDLE_T    = 3'd7
  } init_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_FULL
  } rx_state_e;

  function automatic logic [CNT_W-1:0] region_size(input logic [2:0] t);
    case (t)
      SYSCALL_W: region_size = CNT_W'(SYS_W_BYTES);
      SYSCALL_B: region_size = CNT_W'(SYS_B_BYTES);
      BRANCH_W:  region_size = CNT_W'(BR_W_BYTES);
      BRANCH_B:  region_size = CNT_W'(BR_B_BYTES);
      CONVERT_W: region_size = CNT_W'(CONV_W_BYTES);
      CONVERT_B: region_size = CNT_W'(CONV_B_BYTES);
      default:   region_size = '0;
    endcase
  endfunction

  function automatic logic type_legal(input logic [2:0] t);
    return t <= CONVERT_B;
  endfunction

endpackage

// File: rtl/lstm_init_receiver_packer.sv
// Byte-to-word packer: MSB-first shift register, burst byte counter and registered word strobe.
module lstm_byte_packer
  import lstm_init_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              accept_i,
  input  logic              restart_i,
  input  logic [7:0]        byte_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              ready_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       word_o
);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       shift_q, shift_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q;

  // A restart byte is the first of a burst, so the count restarts at 1 rather than 0.
  always_comb begin
    count_d = count_q;
    shift_d = shift_q;
    ready_d = 1'b0;
    addr_d  = addr_q;
    if (accept_i) begin
      count_d = restart_i ? CNT_W'(1) : count_q + CNT_W'(1);
      shift_d = {shift_q[23:0], byte_i};
      ready_d = (count_d % CNT_W'(WORD_BYTES)) == '0;
      addr_d  = ADDR_W'(count_d / CNT_W'(WORD_BYTES) - CNT_W'(1));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      shift_q <= '0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      word_q  <= '0;
    end else begin
      count_q <= count_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      if (ready_d) begin
        addr_q <= addr_d;
        word_q <= shift_d;
      end
    end
  end

  assign count_o = count_q;
  assign ready_o = ready_q;
  assign addr_o  = addr_q;
  assign word_o  = word_q;

endmodule

// File: rtl/lstm_init_receiver.sv
// Receive side of the LSTM init byte stream: burst FSM, region tracking and protocol-error pulses.
module lstm_init_receiver
  import lstm_init_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iInit_valid,
  input  logic [2:0]        iInit_type,
  input  logic [7:0]        iInit_data,
  output logic              oWr_en,
  output logic [2:0]        oWr_region,
  output logic [ADDR_W-1:0] oWr_addr,
  output logic [31:0]       oWr_data,
  output logic [5:0]        oLoaded,
  output logic              oAll_loaded,
  output logic              oErr_overflow,
  output logic              oErr_partial,
  output logic              oErr_type
);

  rx_state_e        state_q, state_d;
  logic [2:0]       region_q, region_d;
  logic [5:0]       loaded_q, loaded_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_part_q, err_part_d;
  logic             err_type_q, err_type_d;
  logic             accept, restart, start;
  logic             partial;
  logic [CNT_W-1:0] count;
  logic             wr_en;

  lstm_byte_packer #(.ADDR_W(ADDR_W)) u_packer (
    .clk_i     (clk),
    .rst_i     (reset),
    .accept_i  (accept),
    .restart_i (restart),
    .byte_i    (iInit_data),
    .count_o   (count),
    .ready_o   (wr_en),
    .addr_o    (oWr_addr),
    .word_o    (oWr_data)
  );

  assign partial = (count % CNT_W'(WORD_BYTES)) != '0;

  // A type change with valid held closes the old burst and opens the new one in the same cycle.
  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    loaded_d   = loaded_q;
    accept     = 1'b0;
    restart    = 1'b0;
    start      = 1'b0;
    err_ovf_d  = 1'b0;
    err_part_d = 1'b0;
    err_type_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iInit_valid) begin
          if (type_legal(iInit_type)) start = 1'b1;
          else                        err_type_d = 1'b1;
        end
      end
      S_RECV, S_FULL: begin
        if (!iInit_valid) begin
          state_d    = S_IDLE;
          err_part_d = partial;
        end else if (iInit_type == region_q) begin
          if (state_q == S_FULL) begin
            err_ovf_d = 1'b1;
          end else begin
            accept = 1'b1;
            if (count + CNT_W'(1) == region_size(region_q)) begin
              state_d            = S_FULL;
              loaded_d[region_q] = 1'b1;
            end
          end
        end else begin
          err_part_d = partial;
          if (type_legal(iInit_type)) begin
            start = 1'b1;
          end else begin
            state_d    = S_IDLE;
            err_type_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d              = S_RECV;
      region_d             = iInit_type;
      accept               = 1'b1;
      restart              = 1'b1;
      loaded_d[iInit_type] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      region_q   <= '0;
      loaded_q   <= '0;
      err_ovf_q  <= 1'b0;
      err_part_q <= 1'b0;
      err_type_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      loaded_q   <= loaded_d;
      err_ovf_q  <= err_ovf_d;
      err_part_q <= err_part_d;
      err_type_q <= err_type_d;
    end
  end

  // region_q cannot change on the edge that completes a word, so it still names the write's region.
  assign oWr_en        = wr_en;
  assign oWr_region    = wr_en ? region_q : '0;
  assign oLoaded       = loaded_q;
  assign oAll_loaded   = &loaded_q;
  assign oErr_overflow = err_ovf_q;
  assign oErr_partial  = err_part_q;
  assign oErr_type     = err_type_q;

endmodule

// File: tb/tb_lstm_init_receiver.sv
// Randomised bench for lstm_init_receiver against a burst-level model of the init stream.
module tb_lstm_init_receiver;

  localparam int unsigned ADDR_W = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic              iInit_valid;
  logic [2:0]        iInit_type;
  logic [7:0]        iInit_data;
  logic              oWr_en;
  logic [2:0]        oWr_region;
  logic [ADDR_W-1:0] oWr_addr;
  logic [31:0]       oWr_data;
  logic [5:0]        oLoaded;
  logic              oAll_loaded;
  logic              oErr_overflow;
  logic              oErr_partial;
  logic              oErr_type;

  lstm_init_receiver #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .iInit_valid   (iInit_valid),
    .iInit_type    (iInit_type),
    .iInit_data    (iInit_data),
    .oWr_en        (oWr_en),
    .oWr_region    (oWr_region),
    .oWr_addr      (oWr_addr),
    .oWr_data      (oWr_data),
    .oLoaded       (oLoaded),
    .oAll_loaded   (oAll_loaded),
    .oErr_overflow (oErr_overflow),
    .oErr_partial  (oErr_partial),
    .oErr_type     (oErr_type)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]        region;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [5:0]        loaded;
    logic              all_ld;
  } wr_t;

  int unsigned sz [6] = '{512, 32, 32768, 256, 1024, 128};

  wr_t         act_q[$];
  wr_t         exp_q[$];
  logic [2:0]  seg_t[$];
  int unsigned seg_n[$];
  int          seg_base[$];
  int unsigned act_ovf, act_part, act_type;
  int unsigned exp_ovf, exp_part, exp_type;
  logic [5:0]  model_loaded;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always @(negedge clk) begin
    if (oWr_en) act_q.push_back({oWr_region, oWr_addr, oWr_data, oLoaded, oAll_loaded});
    if (oErr_overflow) act_ovf++;
    if (oErr_partial)  act_part++;
    if (oErr_type)     act_type++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_scenario();
    act_q.delete(); exp_q.delete();
    seg_t.delete(); seg_n.delete(); seg_base.delete();
    act_ovf = 0; act_part = 0; act_type = 0;
    exp_ovf = 0; exp_part = 0; exp_type = 0;
  endtask

  task automatic add_seg(input logic [2:0] t, input int unsigned n, input int base);
    seg_t.push_back(t); seg_n.push_back(n); seg_base.push_back(base);
  endtask

  // Drives all segments back to back with valid held; expected writes are derived per segment.
  task automatic drive_stream(input int unsigned gap, input bit hold_end);
    logic [7:0]  b[$];
    logic [2:0]  t;
    int unsigned n, S, take;
    wr_t         w;
    for (int s = 0; s < seg_t.size(); s++) begin
      t = seg_t[s];
      n = seg_n[s];
      b.delete();
      for (int unsigned i = 0; i < n; i++)
        b.push_back(seg_base[s] >= 0 ? 8'(seg_base[s] + int'(i)) : 8'($urandom));
      if (t > 3'd5) begin
        exp_type += n;
      end else begin
        S    = sz[t];
        take = (n < S) ? n : S;
        model_loaded[t] = 1'b0;
        for (int unsigned k = 0; k < take / 4; k++) begin
          if ((k + 1) * 4 == S) model_loaded[t] = 1'b1;
          w = {t, ADDR_W'(k), b[4*k], b[4*k+1], b[4*k+2], b[4*k+3], model_loaded, &model_loaded};
          exp_q.push_back(w);
        end
        if (n > S) exp_ovf += n - S;
        if (n < S && n % 4 != 0) exp_part++;
      end
      for (int unsigned i = 0; i < n; i++) begin
        @(negedge clk);
        iInit_valid = 1'b1; iInit_type = t; iInit_data = b[i];
      end
    end
    if (!hold_end) begin
      @(negedge clk);
      iInit_valid = 1'b0; iInit_type = 3'd7; iInit_data = '0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; iInit_valid = 1'b0; iInit_type = 3'd7; iInit_data = '0;
    model_loaded = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({oWr_en, oWr_region, oWr_addr, oWr_data, oLoaded, oAll_loaded, oErr_overflow, oErr_partial, oErr_type} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b reg=%0d addr=%0d data=%h ld=%b all=%b errs=%b%b%b want all zero",
               oWr_en, oWr_region, oWr_addr, oWr_data, oLoaded, oAll_loaded, oErr_overflow, oErr_partial, oErr_type);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({oWr_en, oLoaded, oErr_overflow, oErr_partial, oErr_type} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got en=%b ld=%b errs=%b%b%b want zero",
               oWr_en, oLoaded, oErr_overflow, oErr_partial, oErr_type);
    end
  endtask

  task automatic test_sys_b();
    start_scenario();
    add_seg(3'd1, 32, 0);
    drive_stream(4, 1'b0);
    n_checks++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL sys_b_count: got %0d writes want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL sys_b_write[%0d]: got %h want %h", i, act_q[i], exp_q[i]);
      end
    end
    if (act_q.size() >= 8) begin
      n_checks++;
      if (act_q[0].data !== 32'h00010203 || act_q[7].data !== 32'h1C1D1E1F || act_q[7].loaded !== 6'b000010) begin
        n_fail++;
        $display("FAIL sys_b_ends: got first=%h last=%h ld=%b want 00010203 1c1d1e1f 000010",
                 act_q[0].data, act_q[7].data, act_q[7].loaded);
      end
    end
    n_checks++;
    if (act_part !== 0 || act_ovf !== 0 || act_type !== 0) begin
      n_fail++; $display("FAIL sys_b_errs: got ovf=%0d part=%0d type=%0d want 0 0 0", act_ovf, act_part, act_type);
    end
  endtask

  task automatic test_overflow();
    start_scenario();
    add_seg(3'd1, 33, -1);
    drive_stream(4, 1'b0);
    n_checks++;
    if (act_q.size() != 8) begin
      n_fail++; $display("FAIL ovf_count: got %0d writes want 8", act_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ovf_write[%0d]: got %h want %h", i, act_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (act_ovf !== 1 || act_part !== 0 || act_type !== 0) begin
      n_fail++; $display("FAIL ovf_errs: got ovf=%0d part=%0d type=%0d want 1 0 0", act_ovf, act_part, act_type);
    end
  endtask

  task automatic test_type_switch();
    start_scenario();
    add_seg(3'd0, 6, 'hA0);
    add_seg(3'd3, 4, 'h10);
    drive_stream(4, 1'b0);
    n_checks++;
    if (act_q.size() != 2) begin
      n_fail++; $display("FAIL switch_count: got %0d writes want 2", act_q.size());
    end else begin
      n_checks++;
      if (act_q[0].region !== 3'd0 || act_q[0].addr !== '0 || act_q[0].data !== 32'hA0A1A2A3 ||
          act_q[1].region !== 3'd3 || act_q[1].addr !== '0 || act_q[1].data !== 32'h10111213) begin
        n_fail++; $display("FAIL switch_writes: got %h %h want sys_w A0A1A2A3 / br_b 10111213", act_q[0], act_q[1]);
      end
    end
    n_checks++;
    if (act_part !== 1 || act_ovf !== 0 || act_type !== 0) begin
      n_fail++; $display("FAIL switch_errs: got ovf=%0d part=%0d type=%0d want 0 1 0", act_ovf, act_part, act_type);
    end
    n_checks++;
    if (oLoaded !== 6'b000010) begin
      n_fail++; $display("FAIL switch_loaded: got %b want 000010", oLoaded);
    end
  endtask

  task automatic test_illegal_type();
    start_scenario();
    add_seg(3'd6, 3, -1);
    drive_stream(4, 1'b0);
    n_checks++;
    if (act_type !== 3 || act_q.size() != 0 || act_ovf !== 0 || act_part !== 0) begin
      n_fail++;
      $display("FAIL illegal_type: got type=%0d writes=%0d ovf=%0d part=%0d want 3 0 0 0",
               act_type, act_q.size(), act_ovf, act_part);
    end
  endtask

  task automatic test_random();
    logic [2:0]  t, prev;
    int unsigned maxlen, n;
    for (int r = 0; r < 25; r++) begin
      start_scenario();
      prev = 3'd7;
      for (int s = 0; s < int'($urandom_range(1, 3)); s++) begin
        do t = 3'($urandom_range(0, 7)); while (t == prev);
        prev = t;
        if (t > 3'd5) begin
          n = $urandom_range(1, 3);
        end else begin
          maxlen = ((sz[t] < 128) ? sz[t] : 128) + 8;
          n = ($urandom_range(0, 3) == 0 && sz[t] <= 256) ? sz[t] : $urandom_range(1, maxlen);
        end
        add_seg(t, n, -1);
      end
      drive_stream(3, 1'b0);
      n_checks++;
      if (act_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d writes want %0d", r, act_q.size(), exp_q.size());
      end
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (act_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_write[%0d]: got %h want %h", r, i, act_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (act_ovf !== exp_ovf || act_part !== exp_part || act_type !== exp_type) begin
        n_fail++;
        $display("FAIL rand%0d_errs: got ovf=%0d part=%0d type=%0d want %0d %0d %0d",
                 r, act_ovf, act_part, act_type, exp_ovf, exp_part, exp_type);
      end
      n_checks++;
      if (oLoaded !== model_loaded) begin
        n_fail++; $display("FAIL rand%0d_loaded: got %b want %b", r, oLoaded, model_loaded);
      end
    end
  endtask

  task automatic test_full_load();
    int unsigned br_max;
    int unsigned mism;
    start_scenario();
    for (int t = 0; t < 6; t++) begin
      seg_t.delete(); seg_n.delete(); seg_base.delete();
      add_seg(3'(t), sz[t], -1);
      drive_stream(10, 1'b0);
    end
    n_checks++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL full_count: got %0d writes want %0d", act_q.size(), exp_q.size());
    end
    mism = 0;
    br_max = 0;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      if (act_q[i] !== exp_q[i]) begin
        if (mism < 5) $display("FAIL full_write[%0d]: got %h want %h", i, act_q[i], exp_q[i]);
        mism++;
      end
      if (act_q[i].region == 3'd2 && int'(act_q[i].addr) > br_max) br_max = act_q[i].addr;
    end
    n_checks++;
    if (mism != 0) begin
      n_fail++; $display("FAIL full_writes: got %0d mismatching writes want 0", mism);
    end
    n_checks++;
    if (br_max != 8191) begin
      n_fail++; $display("FAIL full_br_w_last: got addr %0d want 8191", br_max);
    end
    n_checks++;
    if (oAll_loaded !== 1'b1 || oLoaded !== 6'b111111) begin
      n_fail++; $display("FAIL full_all_loaded: got all=%b ld=%b want 1 111111", oAll_loaded, oLoaded);
    end
    n_checks++;
    if (act_ovf !== 0 || act_part !== 0 || act_type !== 0) begin
      n_fail++; $display("FAIL full_errs: got ovf=%0d part=%0d type=%0d want 0 0 0", act_ovf, act_part, act_type);
    end
  endtask

  task automatic test_reset_mid();
    start_scenario();
    add_seg(3'd2, 1000, -1);
    drive_stream(0, 1'b1);
    @(negedge clk);
    iInit_data = 8'($urandom);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({oWr_en, oWr_region, oWr_addr, oWr_data, oLoaded, oAll_loaded, oErr_overflow, oErr_partial, oErr_type} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got en=%b addr=%0d data=%h ld=%b all=%b want all zero",
               oWr_en, oWr_addr, oWr_data, oLoaded, oAll_loaded);
    end
    model_loaded = '0;
    n_checks++;
    if (act_q.size() != 250 || act_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midreset_count: got %0d writes want 250", act_q.size());
    end else begin
      n_checks++;
      if (act_q[249] !== exp_q[249]) begin
        n_fail++; $display("FAIL midreset_last: got %h want %h", act_q[249], exp_q[249]);
      end
    end
    @(negedge clk);
    reset = 1'b0; iInit_valid = 1'b0; iInit_type = 3'd7;
    @(negedge clk);
    start_scenario();
    add_seg(3'd2, 8, -1);
    drive_stream(4, 1'b0);
    n_checks++;
    if (act_q.size() != 2) begin
      n_fail++; $display("FAIL restart_count: got %0d writes want 2", act_q.size());
    end else begin
      n_checks++;
      if (act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1] || act_q[1].addr !== ADDR_W'(1)) begin
        n_fail++; $display("FAIL restart_writes: got %h %h want %h %h", act_q[0], act_q[1], exp_q[0], exp_q[1]);
      end
    end
    n_checks++;
    if (oLoaded !== '0) begin
      n_fail++; $display("FAIL restart_loaded: got %b want 000000", oLoaded);
    end
  endtask

  initial begin
    test_reset();
    test_sys_b();
    test_overflow();
    test_type_switch();
    test_illegal_type();
    test_random();
    test_full_load();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
